ram_fifo_ctrl: RTL and testbench

- FIFO sequencer placed directly upstream of the 16x4 single-port RAM.
- Turns a push/pop valid-ready handshake into the RAM's Data, Address, WR and RD strobes.
- Returns read data from the RAM's Out port together with a valid flag.
- Tracks occupancy with write/read pointers and a count, so producers and consumers never handle RAM addresses.

---
 rtl/ram_fifo_ctrl.sv | 118 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO sequencer in front of a single-port RAM.
// Converts push/pop valid-ready handshakes into registered RAM
// Data/Address/WR/RD strobes and returns read data with a valid flag.
// A single-port RAM accepts one operation per cycle. When a pop and a push are
// both possible in the same cycle, the pop is accepted.
module ram_fifo_ctrl #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_valid,
    output logic              pop_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic              ram_rd,
    input  logic [DATA_W-1:0] ram_out,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              ovf_err
);

    localparam int unsigned      DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0]  DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ram_wr_q, ram_wr_d;
    logic              ram_rd_q, ram_rd_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;
    logic              dout_valid_q, dout_valid_d;
    logic              ovf_err_q, ovf_err_d;

    logic push_acc;
    logic pop_acc;

    // Handshake decode: the pop has priority, so a push yields whenever a pop is possible
    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == DEPTH_C);
        pop_ready  = !empty;
        push_ready = !full && !(pop_valid && !empty);
        pop_acc    = pop_valid && pop_ready;
        push_acc   = push_valid && push_ready;
    end

    // Next-state: pointers, occupancy, registered RAM strobes, read-valid pipeline
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ram_wr_d     = 1'b0;
        ram_rd_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_data_d   = ram_data_q;
        dout_valid_d = ram_rd_q;
        ovf_err_d    = ovf_err_q || (push_valid && full);
        if (pop_acc) begin
            ram_rd_d   = 1'b1;
            ram_addr_d = rd_ptr_q;
            rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
            count_d    = count_q - (ADDR_W + 1)'(1);
        end else if (push_acc) begin
            ram_wr_d   = 1'b1;
            ram_addr_d = wr_ptr_q;
            ram_data_d = push_data;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            count_d    = count_q + (ADDR_W + 1)'(1);
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ram_wr_q     <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            dout_valid_q <= 1'b0;
            ovf_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ram_wr_q     <= ram_wr_d;
            ram_rd_q     <= ram_rd_d;
            ram_addr_q   <= ram_addr_d;
            ram_data_q   <= ram_data_d;
            dout_valid_q <= dout_valid_d;
            ovf_err_q    <= ovf_err_d;
        end
    end

    // Output mapping
    always_comb begin
        ram_wr     = ram_wr_q;
        ram_rd     = ram_rd_q;
        ram_addr   = ram_addr_q;
        ram_data   = ram_data_q;
        count      = count_q;
        dout_valid = dout_valid_q;
        dout       = ram_out;
        ovf_err    = ovf_err_q;
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed self-checking bench for ram_fifo_ctrl with a behavioural 16x4 RAM.
module tb_ram_fifo_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push_valid;
    logic       push_ready;
    logic [3:0] push_data;
    logic       pop_valid;
    logic       pop_ready;
    logic [3:0] dout;
    logic       dout_valid;
    logic [3:0] ram_data;
    logic [3:0] ram_addr;
    logic       ram_wr;
    logic       ram_rd;
    logic [3:0] ram_out;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       ovf_err;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [16];

    ram_fifo_ctrl #(.DATA_W(4), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_data  (push_data),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_wr     (ram_wr),
        .ram_rd     (ram_rd),
        .ram_out    (ram_out),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: write at the edge ending a WR cycle; read data held through the following cycle
    initial ram_out = '0;
    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_data;
        if (ram_rd) ram_out <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_valid  = 1'b0;
        #2;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_ram_wr", 32'(ram_wr), 0);
        chk("rst_ram_rd", 32'(ram_rd), 0);
        chk("rst_dout_valid", 32'(dout_valid), 0);
        chk("rst_ovf", 32'(ovf_err), 0);
        chk("rst_addr", 32'(ram_addr), 0);
        chk("rst_data", 32'(ram_data), 0);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Two pushes: 0x3 then 0x9
        push_valid = 1'b1;
        push_data  = 4'h3;
        #1;
        chk("p1_push_ready", 32'(push_ready), 1);
        cyc();
        chk("p1_wr", 32'(ram_wr), 1);
        chk("p1_addr", 32'(ram_addr), 0);
        chk("p1_data", 32'(ram_data), 3);
        chk("p1_count", 32'(count), 1);
        push_data = 4'h9;
        cyc();
        chk("p2_wr", 32'(ram_wr), 1);
        chk("p2_addr", 32'(ram_addr), 1);
        chk("p2_data", 32'(ram_data), 9);
        chk("p2_count", 32'(count), 2);
        push_valid = 1'b0;
        cyc();
        chk("idle_wr", 32'(ram_wr), 0);
        chk("idle_addr_hold", 32'(ram_addr), 1);
        chk("idle_data_hold", 32'(ram_data), 9);

        // Two pops: expect 0x3 then 0x9 two cycles after acceptance
        pop_valid = 1'b1;
        cyc();
        chk("r1_rd", 32'(ram_rd), 1);
        chk("r1_addr", 32'(ram_addr), 0);
        chk("r1_count", 32'(count), 1);
        chk("r1_dv", 32'(dout_valid), 0);
        cyc();
        chk("r2_rd", 32'(ram_rd), 1);
        chk("r2_addr", 32'(ram_addr), 1);
        chk("r2_count", 32'(count), 0);
        chk("r2_dv", 32'(dout_valid), 1);
        chk("r2_dout", 32'(dout), 3);
        pop_valid = 1'b0;
        cyc();
        chk("r3_rd", 32'(ram_rd), 0);
        chk("r3_dv", 32'(dout_valid), 1);
        chk("r3_dout", 32'(dout), 9);
        cyc();
        chk("r4_dv", 32'(dout_valid), 0);
        chk("r4_empty", 32'(empty), 1);

        // Fill with 0x0..0xF starting at address 2; address wraps 15 -> 0
        push_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push_data = 4'(i);
            cyc();
            chk("fill_wr", 32'(ram_wr), 1);
            chk("fill_addr", 32'(ram_addr), 32'((2 + i) % 16));
            chk("fill_data", 32'(ram_data), 32'(i));
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        push_data = 4'h5;
        #1;
        chk("full_flag", 32'(full), 1);
        chk("full_push_ready", 32'(push_ready), 0);
        chk("full_ovf_before", 32'(ovf_err), 0);
        cyc();
        chk("ovf_set", 32'(ovf_err), 1);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_no_wr", 32'(ram_wr), 0);
        push_valid = 1'b0;

        // Drain all 16: data returns 0x0..0xF in order
        pop_valid = 1'b1;
        for (int j = 1; j <= 18; j++) begin
            cyc();
            if (j <= 16) begin
                chk("drain_rd", 32'(ram_rd), 1);
                chk("drain_addr", 32'(ram_addr), 32'((1 + j) % 16));
                chk("drain_count", 32'(count), 32'(16 - j));
            end else begin
                chk("drain_rd_off", 32'(ram_rd), 0);
            end
            chk("drain_dv", 32'(dout_valid), (j >= 2 && j <= 17) ? 1 : 0);
            if (j >= 2 && j <= 17) chk("drain_dout", 32'(dout), 32'(j - 2));
        end

        // Pop while empty is ignored
        chk("empty_pop_ready", 32'(pop_ready), 0);
        cyc();
        chk("empty_no_rd", 32'(ram_rd), 0);
        cyc();
        chk("empty_no_dv", 32'(dout_valid), 0);
        chk("empty_count", 32'(count), 0);
        pop_valid = 1'b0;

        // Load five words 0xA..0xE (addresses 2..6)
        push_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_data = 4'(10 + i);
            cyc();
        end
        push_valid = 1'b0;
        cyc();
        chk("five_count", 32'(count), 5);

        // Simultaneous push and pop: pops win until empty, then the push goes in
        push_valid = 1'b1;
        pop_valid  = 1'b1;
        push_data  = 4'h7;
        #1;
        chk("both_push_ready", 32'(push_ready), 0);
        chk("both_pop_ready", 32'(pop_ready), 1);
        for (int j = 1; j <= 5; j++) begin
            cyc();
            chk("both_rd", 32'(ram_rd), 1);
            chk("both_wr", 32'(ram_wr), 0);
            chk("both_addr", 32'(ram_addr), 32'(1 + j));
            chk("both_count", 32'(count), 32'(5 - j));
            chk("both_dv", 32'(dout_valid), (j >= 2) ? 1 : 0);
            if (j >= 2) chk("both_dout", 32'(dout), 32'(10 + j - 2));
            if (j < 5) chk("both_push_blocked", 32'(push_ready), 0);
        end
        chk("after_empty_push_ready", 32'(push_ready), 1);
        cyc();
        pop_valid  = 1'b0;
        push_valid = 1'b0;
        chk("late_push_wr", 32'(ram_wr), 1);
        chk("late_push_addr", 32'(ram_addr), 7);
        chk("late_push_data", 32'(ram_data), 7);
        chk("late_push_count", 32'(count), 1);
        chk("late_dv", 32'(dout_valid), 1);
        chk("late_dout", 32'(dout), 4'hE);
        chk("ovf_sticky", 32'(ovf_err), 1);
        cyc();

        // Pop accepted, then reset before the word returns
        pop_valid = 1'b1;
        cyc();
        pop_valid = 1'b0;
        chk("mid_rd", 32'(ram_rd), 1);
        chk("mid_count", 32'(count), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dv", 32'(dout_valid), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_ovf", 32'(ovf_err), 0);
        chk("mid_rst_rd", 32'(ram_rd), 0);
        cyc();
        chk("mid_rst_dv2", 32'(dout_valid), 0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_dv", 32'(dout_valid), 0);
        chk("post_rst_empty", 32'(empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
